// File: rtl/tcp_tx_flag_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tcp_tx_flag_sched_pkg
// Brief    : Shared types and constants for the per-flow TX flag scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package tcp_tx_flag_sched_pkg;

  localparam int FLOWID_W        = 3;
  localparam int SCHED_TS_W      = 4;
  localparam int SCHED_NUM_FLAGS = 3;

  // Flag positions inside every flag vector / snapshot
  localparam int SCHED_RT_IDX    = 0;
  localparam int SCHED_ACK_IDX   = 1;
  localparam int SCHED_DATA_IDX  = 2;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    SET   = 2'd1,
    CLEAR = 2'd2
  } sched_cmd_e;

  typedef struct packed {
    logic                  flag;
    logic [SCHED_TS_W-1:0] timestamp;
  } sched_flag_struct;

  typedef struct packed {
    sched_cmd_e            cmd;
    logic [SCHED_TS_W-1:0] timestamp;
  } sched_flag_cmd_struct;

  typedef struct packed {
    logic [FLOWID_W-1:0]                     flowid;
    sched_flag_struct [SCHED_NUM_FLAGS-1:0]  flags;
  } sched_data_struct;

  typedef struct packed {
    logic [FLOWID_W-1:0]                       flowid;
    sched_flag_cmd_struct [SCHED_NUM_FLAGS-1:0] cmds;
  } sched_cmd_struct;

endpackage
`default_nettype wire

// File: rtl/tcp_tx_flag_sched_flag_entry.sv
`default_nettype none
// ============================================================================
// Module   : sched_flag_entry
// Brief    : One flow's pending-flag state: three {flag, ts} pairs plus the
//            in-flight (busy) bit, with set / timestamp-guarded clear logic.
// Revision : 1.0 - initial release
// ============================================================================
module sched_flag_entry
  import tcp_tx_flag_sched_pkg::*;
#(
  parameter int TS_W = SCHED_TS_W
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     i_set,
  input  logic [SCHED_NUM_FLAGS-1:0]               i_set_mask,
  input  logic                                     i_upd_val,
  input  sched_flag_cmd_struct [SCHED_NUM_FLAGS-1:0] i_upd_cmd,
  input  logic                                     i_issue,
  output logic [SCHED_NUM_FLAGS-1:0]               o_flag,
  output logic [SCHED_NUM_FLAGS-1:0][TS_W-1:0]     o_ts,
  output logic                                     o_busy
);

  logic r_busy;

  for (genvar k = 0; k < SCHED_NUM_FLAGS; k++) begin : g_flag
    logic            r_flag;
    logic [TS_W-1:0] r_ts;
    logic            w_set;
    logic            w_clr;

    // A set from either source bumps the timestamp; a clear only lands when
    // the returned timestamp matches, so a set made while in flight survives.
    assign w_set = (i_set && i_set_mask[k]) ||
                   (i_upd_val && (i_upd_cmd[k].cmd == SET));
    assign w_clr = i_upd_val && (i_upd_cmd[k].cmd == CLEAR) &&
                   (r_ts == i_upd_cmd[k].timestamp);

    // Flag/timestamp pair; set has priority over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_flag <= 1'b0;
        r_ts   <= '0;
      end else if (w_set) begin
        r_flag <= 1'b1;
        r_ts   <= r_ts + 1'b1;
      end else if (w_clr) begin
        r_flag <= 1'b0;
      end
    end

    assign o_flag[k] = r_flag;
    assign o_ts[k]   = r_ts;
  end

  // Busy marks the flow as issued until its update command comes back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else if (i_issue) begin
      r_busy <= 1'b1;
    end else if (i_upd_val) begin
      r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/tcp_tx_flag_sched.sv
`default_nettype none
// ============================================================================
// Module   : tcp_tx_flag_sched
// Brief    : Round-robin per-flow TX scheduler. Scans the flag table, issues
//            one snapshot request at a time and applies returned updates.
// Revision : 1.0 - initial release
// ============================================================================
module tcp_tx_flag_sched
  import tcp_tx_flag_sched_pkg::*;
#(
  parameter int NUM_FLOWS = 2**FLOWID_W,
  parameter int TS_W      = SCHED_TS_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_set_val,
  input  logic [FLOWID_W-1:0]        i_set_flowid,
  input  logic [SCHED_NUM_FLAGS-1:0] i_set_mask,
  output logic                       o_sched_tx_req_val,
  input  logic                       i_sched_tx_req_rdy,
  output sched_data_struct           o_sched_tx_req_data,
  input  logic                       i_tx_sched_update_val,
  input  sched_cmd_struct            i_tx_sched_update_cmd
);

  localparam logic [FLOWID_W-1:0] LAST_FLOW = FLOWID_W'(NUM_FLOWS - 1);

  logic [FLOWID_W-1:0]                 r_scan_ptr;
  logic                                r_valid;
  sched_data_struct                    r_data;

  logic [SCHED_NUM_FLAGS-1:0]          w_flag [NUM_FLOWS];
  logic [SCHED_NUM_FLAGS-1:0][TS_W-1:0] w_ts  [NUM_FLOWS];
  logic [NUM_FLOWS-1:0]                w_busy;
  logic [NUM_FLOWS-1:0]                w_set_hit;
  logic [NUM_FLOWS-1:0]                w_upd_hit;
  logic [NUM_FLOWS-1:0]                w_issue;
  logic                                w_cand;
  logic                                w_slot_free;
  logic                                w_load;
  sched_data_struct                    w_snap;

  for (genvar f = 0; f < NUM_FLOWS; f++) begin : g_entry
    assign w_set_hit[f] = i_set_val && (i_set_flowid == FLOWID_W'(f));
    assign w_upd_hit[f] = i_tx_sched_update_val &&
                          (i_tx_sched_update_cmd.flowid == FLOWID_W'(f));
    assign w_issue[f]   = w_load && (r_scan_ptr == FLOWID_W'(f));

    sched_flag_entry #(
      .TS_W (TS_W)
    ) u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_set      (w_set_hit[f]),
      .i_set_mask (i_set_mask),
      .i_upd_val  (w_upd_hit[f]),
      .i_upd_cmd  (i_tx_sched_update_cmd.cmds),
      .i_issue    (w_issue[f]),
      .o_flag     (w_flag[f]),
      .o_ts       (w_ts[f]),
      .o_busy     (w_busy[f])
    );
  end

  // Candidate mux: the flow under the scan pointer, snapshotted pre-edge
  always_comb begin
    w_snap        = '0;
    w_snap.flowid = r_scan_ptr;
    for (int k = 0; k < SCHED_NUM_FLAGS; k++) begin
      w_snap.flags[k].flag      = w_flag[r_scan_ptr][k];
      w_snap.flags[k].timestamp = w_ts[r_scan_ptr][k];
    end
  end

  assign w_cand      = (|w_flag[r_scan_ptr]) && !w_busy[r_scan_ptr];
  assign w_slot_free = !r_valid || i_sched_tx_req_rdy;
  assign w_load      = w_slot_free && w_cand;

  // Scan pointer walks every cycle except while a held request is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_ptr <= '0;
    end else if (w_slot_free) begin
      r_scan_ptr <= (r_scan_ptr == LAST_FLOW) ? '0 : r_scan_ptr + 1'b1;
    end
  end

  // One-entry output slot; contents frozen while valid and not accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_snap;
    end else if (i_sched_tx_req_rdy) begin
      r_valid <= 1'b0;
    end
  end

  assign o_sched_tx_req_val  = r_valid;
  assign o_sched_tx_req_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_tcp_tx_flag_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcp_tx_flag_sched
// Brief    : Self-checking bench: directed scenarios plus random traffic,
//            compared every cycle against a table-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tcp_tx_flag_sched;
  import tcp_tx_flag_sched_pkg::*;

  localparam int N   = 2**FLOWID_W;
  localparam int TSM = 2**SCHED_TS_W;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                set_val = 1'b0;
  logic [FLOWID_W-1:0] set_flowid = '0;
  logic [2:0]          set_mask = '0;
  logic                rdy = 1'b1;
  logic                req_val;
  sched_data_struct    req_data;
  logic                upd_val = 1'b0;
  sched_cmd_struct     upd_cmd = '0;

  always #5 clk = ~clk;

  tcp_tx_flag_sched dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_set_val             (set_val),
    .i_set_flowid          (set_flowid),
    .i_set_mask            (set_mask),
    .o_sched_tx_req_val    (req_val),
    .i_sched_tx_req_rdy    (rdy),
    .o_sched_tx_req_data   (req_data),
    .i_tx_sched_update_val (upd_val),
    .i_tx_sched_update_cmd (upd_cmd)
  );

  // Behavioural model: the flag table as plain arrays
  bit               m_flag [N][3];
  int               m_ts   [N][3];
  bit               m_busy [N];
  int               m_ptr;
  bit               m_valid;
  sched_data_struct m_data;
  sched_data_struct acc_q [$];

  int vectors = 0;
  int errors  = 0;

  task automatic model_reset();
    for (int f = 0; f < N; f++) begin
      m_busy[f] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        m_flag[f][k] = 1'b0;
        m_ts[f][k]   = 0;
      end
    end
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = '0;
    acc_q.delete();
  endtask

  // One clock edge of the model, using the inputs held during the cycle
  task automatic model_step();
    bit accept, free, load, s, c;
    int p;
    sched_data_struct snap;
    p      = m_ptr;
    accept = m_valid && rdy;
    free   = !m_valid || rdy;
    load   = free && (m_flag[p][0] || m_flag[p][1] || m_flag[p][2]) && !m_busy[p];
    if (accept) acc_q.push_back(m_data);
    snap = '0;
    snap.flowid = FLOWID_W'(p);
    for (int k = 0; k < 3; k++) begin
      snap.flags[k].flag      = m_flag[p][k];
      snap.flags[k].timestamp = SCHED_TS_W'(m_ts[p][k]);
    end
    for (int f = 0; f < N; f++) begin
      for (int k = 0; k < 3; k++) begin
        s = (set_val && int'(set_flowid) == f && set_mask[k]) ||
            (upd_val && int'(upd_cmd.flowid) == f && upd_cmd.cmds[k].cmd == SET);
        c = upd_val && int'(upd_cmd.flowid) == f && upd_cmd.cmds[k].cmd == CLEAR &&
            m_ts[f][k] == int'(upd_cmd.cmds[k].timestamp);
        if (s) begin
          m_flag[f][k] = 1'b1;
          m_ts[f][k]   = (m_ts[f][k] + 1) % TSM;
        end else if (c) begin
          m_flag[f][k] = 1'b0;
        end
      end
    end
    if (upd_val) m_busy[upd_cmd.flowid] = 1'b0;
    if (load) begin
      m_busy[p] = 1'b1;
      m_valid   = 1'b1;
      m_data    = snap;
    end else if (accept) begin
      m_valid = 1'b0;
    end
    if (free) m_ptr = (m_ptr + 1) % N;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare();
    check("valid", {63'd0, req_val}, {63'd0, m_valid});
    check("no_x", {63'd0, $isunknown({req_val, req_data})}, 64'd0);
    if (m_valid) check("data", 64'(req_data), 64'(m_data));
  endtask

  // Advance one clock: model steps on the edge, outputs checked mid-cycle
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare();
    set_val  = 1'b0;
    set_mask = '0;
    upd_val  = 1'b0;
    upd_cmd  = '0;
  endtask

  function automatic sched_data_struct mk(int f, int k, int ts);
    sched_data_struct e;
    e = '0;
    e.flowid = FLOWID_W'(f);
    e.flags[k].flag      = 1'b1;
    e.flags[k].timestamp = SCHED_TS_W'(ts);
    return e;
  endfunction

  task automatic do_set(int f, logic [2:0] mask);
    set_val    = 1'b1;
    set_flowid = FLOWID_W'(f);
    set_mask   = mask;
    cycle();
  endtask

  task automatic do_upd(int f, int k, sched_cmd_e cmd, int ts);
    upd_val = 1'b1;
    upd_cmd = '0;
    upd_cmd.flowid            = FLOWID_W'(f);
    upd_cmd.cmds[k].cmd       = cmd;
    upd_cmd.cmds[k].timestamp = SCHED_TS_W'(ts);
    cycle();
  endtask

  task automatic wait_req(output sched_data_struct d);
    d = '0;
    for (int i = 0; i < 2*N+4; i++) begin
      if (req_val === 1'b1) begin
        d = req_data;
        return;
      end
      cycle();
    end
    vectors++;
    errors++;
    $display("FAIL wait_req: no request within %0d cycles, expected one", 2*N+4);
  endtask

  task automatic wait_ptr(int p);
    for (int i = 0; i < 2*N; i++) begin
      if (m_ptr == p) return;
      cycle();
    end
    vectors++;
    errors++;
    $display("FAIL wait_ptr: model pointer %0d, expected %0d", m_ptr, p);
  endtask

  task automatic no_issue(string name);
    int cnt;
    cnt = 0;
    for (int i = 0; i < N+3; i++) begin
      cycle();
      if (req_val !== 1'b0) cnt++;
    end
    check(name, 64'(cnt), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    sched_data_struct d;
    sched_data_struct s;
    int r;
    model_reset();
    #2 rst_n = 1'b0;
    cycle();
    cycle();
    check("reset_val", {63'd0, req_val}, 64'd0);
    check("reset_data", 64'(req_data), 64'd0);
    rst_n = 1'b1;

    // Ack-pending on flow 3, then matching CLEAR retires it
    do_set(3, 3'b010);
    wait_req(d);
    check("t1_req", 64'(d), 64'(mk(3, SCHED_ACK_IDX, 1)));
    do_upd(3, SCHED_ACK_IDX, CLEAR, 1);
    check("t1_model_flag", {63'd0, m_flag[3][1]}, 64'd0);
    no_issue("t1_no_reissue");

    // Set while in flight survives a stale CLEAR
    wait_ptr(6);
    do_set(5, 3'b100);
    do_set(5, 3'b100);
    wait_req(d);
    check("t2_first", 64'(d), 64'(mk(5, SCHED_DATA_IDX, 2)));
    do_set(5, 3'b100);
    do_upd(5, SCHED_DATA_IDX, CLEAR, 2);
    check("t2_model_ts", 64'(m_ts[5][2]), 64'd3);
    wait_req(d);
    check("t2_reissue", 64'(d), 64'(mk(5, SCHED_DATA_IDX, 3)));
    do_upd(5, SCHED_DATA_IDX, CLEAR, 3);

    // Set and matching CLEAR in the same cycle: set wins
    wait_ptr(7);
    for (int i = 0; i < 4; i++) do_set(6, 3'b010);
    check("t3_model_ts4", 64'(m_ts[6][1]), 64'd4);
    wait_req(d);
    check("t3_first", 64'(d), 64'(mk(6, SCHED_ACK_IDX, 4)));
    set_val = 1'b1; set_flowid = 3'd6; set_mask = 3'b010;
    upd_val = 1'b1; upd_cmd = '0; upd_cmd.flowid = 3'd6;
    upd_cmd.cmds[1].cmd = CLEAR; upd_cmd.cmds[1].timestamp = 4'd4;
    cycle();
    check("t3_model_flag", {63'd0, m_flag[6][1]}, 64'd1);
    check("t3_model_ts5", 64'(m_ts[6][1]), 64'd5);
    wait_req(d);
    check("t3_reissue", 64'(d), 64'(mk(6, SCHED_ACK_IDX, 5)));
    do_upd(6, SCHED_ACK_IDX, CLEAR, 5);

    // Back-pressure: slot holds flow 0, then 0,1,2 drain back-to-back
    rdy = 1'b0;
    wait_ptr(3);
    do_set(0, 3'b001);
    do_set(1, 3'b001);
    do_set(2, 3'b001);
    wait_req(d);
    check("t4_first", 64'(d), 64'(mk(0, SCHED_RT_IDX, 1)));
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t4_hold_val", {63'd0, req_val}, 64'd1);
      check("t4_hold_data", 64'(req_data), 64'(mk(0, SCHED_RT_IDX, 1)));
    end
    rdy = 1'b1;
    cycle();
    check("t4_flow1", {req_val, 64'(req_data)}, {1'b1, 64'(mk(1, SCHED_RT_IDX, 1))});
    cycle();
    check("t4_flow2", {req_val, 64'(req_data)}, {1'b1, 64'(mk(2, SCHED_RT_IDX, 1))});
    do_upd(0, SCHED_RT_IDX, CLEAR, 1);
    do_upd(1, SCHED_RT_IDX, CLEAR, 1);
    do_upd(2, SCHED_RT_IDX, CLEAR, 1);
    no_issue("t4_drained");

    // Timestamp wrap: 16 sets take ts back to 0; CLEAR 0 retires the flag
    rdy = 1'b0;
    do_set(7, 3'b100);
    wait_req(d);
    check("t5_hold7", 64'(d), 64'(mk(7, SCHED_DATA_IDX, 1)));
    for (int i = 0; i < TSM; i++) do_set(4, 3'b001);
    check("t5_model_wrap", {m_flag[4][0], 64'(m_ts[4][0])}, {1'b1, 64'd0});
    rdy = 1'b1;
    cycle();
    wait_req(d);
    check("t5_wrapped", 64'(d), 64'(mk(4, SCHED_RT_IDX, 0)));
    do_upd(4, SCHED_RT_IDX, CLEAR, 0);
    no_issue("t5_cleared");

    // Asynchronous reset with flow 7 busy and a request pending
    rdy = 1'b0;
    do_set(1, 3'b001);
    wait_req(d);
    check("t6_pending", 64'(d), 64'(mk(1, SCHED_RT_IDX, 2)));
    rst_n = 1'b0;
    #1;
    check("t6_rst_val", {63'd0, req_val}, 64'd0);
    check("t6_rst_data", 64'(req_data), 64'd0);
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    rdy   = 1'b1;
    do_upd(7, SCHED_DATA_IDX, CLEAR, 1);
    no_issue("t6_stale_clear");

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        set_val    = 1'b1;
        set_flowid = FLOWID_W'($urandom);
        set_mask   = 3'($urandom);
      end
      if (acc_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        s = acc_q.pop_front();
        upd_val = 1'b1;
        upd_cmd = '0;
        upd_cmd.flowid = s.flowid;
        for (int k = 0; k < 3; k++) begin
          r = int'($urandom_range(0, 3));
          upd_cmd.cmds[k].cmd = (r == 0) ? NOP : (r == 1) ? SET : CLEAR;
          upd_cmd.cmds[k].timestamp = ($urandom_range(0, 1) == 1) ?
              s.flags[k].timestamp : SCHED_TS_W'($urandom);
        end
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
